sha256_padder: RTL

- Producer side of the SHA-256 message-scheduler word interface: accepts a byte stream and builds 512-bit blocks with FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length).
- Streams each block as 16 big-endian words, then holds the block-full handshake until the compression core signals digest done.
- Sits between the HMAC message/key source and the scheduler + compression core.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_padder_if.sv | 28 ++
 rtl/sha256_block_buf.sv | 40 ++++
 rtl/sha256_padder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_LEN,
    S_STREAM,
    S_HASH
  } state_e;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam logic [5:0]  LEN_POS     = 6'd56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-stream input and scheduler word output of the SHA-256 padder.
interface sha256_padder_if;

  logic        msg_valid;
  logic [7:0]  msg_data;
  logic        msg_last;
  logic        msg_flush;
  logic        msg_ready;
  logic        done_digest;
  logic [31:0] data_out;
  logic        flag_0_15;
  logic        block_full;
  logic        first_block;
  logic        last_block;
  logic        msg_done;
  logic        busy;

  modport master (
    output msg_valid, msg_data, msg_last, msg_flush, done_digest,
    input  msg_ready, data_out, flag_0_15, block_full, first_block, last_block, msg_done, busy
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, msg_flush, done_digest,
    output msg_ready, data_out, flag_0_15, block_full, first_block, last_block, msg_done, busy
  );

endinterface

// File: rtl/sha256_block_buf.sv
// 16x32 block buffer: byte-lane writes (big-endian within a word), length write, clear, word read.
module sha256_block_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_we_i,
  input  logic [5:0]  byte_idx_i,
  input  logic [7:0]  byte_i,
  input  logic        len_we_i,
  input  logic [63:0] len_i,
  input  logic [3:0]  rd_idx_i,
  output logic [31:0] rd_word_o
);

  logic [15:0][31:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      mem_d = '0;
    end else if (len_we_i) begin
      mem_d[14] = len_i[63:32];
      mem_d[15] = len_i[31:0];
    end else if (byte_we_i) begin
      // Lane 3-(b%4) equals the inverted low index bits.
      mem_d[byte_idx_i[5:2]][{~byte_idx_i[1:0], 3'b000} +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_word_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs bytes into 512-bit blocks with FIPS 180-4 padding and streams 16 words.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_OFFSET = 0
) (
  input logic             clk,
  input logic             rst,
  sha256_padder_if.slave  bus
);

  localparam logic [63:0] LenInit = 64'(LEN_OFFSET) * 64'd8;
  localparam logic [5:0]  LastIdx = 6'(BLOCK_BYTES - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [63:0] len_q, len_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] hold_q, hold_d;
  logic        pad80_q, pad80_d;
  logic        final_q, final_d;
  logic        pend_q, pend_d;
  logic        first_q, first_d;
  logic        done_q, done_d;
  logic        rdy_en_q;

  logic        byte_we, len_we, clr, accept;
  logic [7:0]  wr_byte;
  logic [31:0] rd_word;

  assign accept = bus.msg_valid && bus.msg_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    k_d     = k_q;
    hold_d  = hold_q;
    pad80_d = pad80_q;
    final_d = final_q;
    pend_d  = pend_q;
    first_d = first_q;
    done_d  = 1'b0;
    byte_we = 1'b0;
    wr_byte = bus.msg_data;
    len_we  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          byte_we = 1'b1;
          idx_d   = idx_q + 6'd1;
          len_d   = len_q + 64'd8;
          pad80_d = 1'b0;
          if (idx_q == LastIdx) begin
            // A full block streams first; a same-cycle end resumes padding afterwards.
            state_d = S_STREAM;
            final_d = 1'b0;
            pend_d  = bus.msg_last;
          end else if (bus.msg_last) begin
            state_d = S_PAD;
          end
        end else if (bus.msg_flush) begin
          state_d = S_PAD;
          pad80_d = 1'b0;
        end
      end
      S_PAD: begin
        idx_d  = idx_q + 6'd1;
        pend_d = 1'b0;
        if (!pad80_q) begin
          byte_we = 1'b1;
          wr_byte = PAD_BYTE;
          pad80_d = 1'b1;
        end
        if (idx_d == LEN_POS) begin
          state_d = S_LEN;
        end else if (idx_d == 6'd0) begin
          state_d = S_STREAM;
          final_d = 1'b0;
        end
      end
      S_LEN: begin
        len_we  = 1'b1;
        state_d = S_STREAM;
        final_d = 1'b1;
      end
      S_STREAM: begin
        hold_d = rd_word;
        k_d    = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d = S_HASH;
        end
      end
      S_HASH: begin
        if (bus.done_digest) begin
          clr     = 1'b1;
          idx_d   = '0;
          first_d = final_q;
          if (final_q) begin
            done_d  = 1'b1;
            len_d   = LenInit;
            final_d = 1'b0;
            pad80_d = 1'b0;
            state_d = S_FILL;
          end else if (pad80_q || pend_q) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FILL;
      idx_q    <= '0;
      len_q    <= LenInit;
      k_q      <= '0;
      hold_q   <= '0;
      pad80_q  <= 1'b0;
      final_q  <= 1'b0;
      pend_q   <= 1'b0;
      first_q  <= 1'b1;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      k_q      <= k_d;
      hold_q   <= hold_d;
      pad80_q  <= pad80_d;
      final_q  <= final_d;
      pend_q   <= pend_d;
      first_q  <= first_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  sha256_block_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .byte_we_i  (byte_we),
    .byte_idx_i (idx_q),
    .byte_i     (wr_byte),
    .len_we_i   (len_we),
    .len_i      (len_q),
    .rd_idx_i   (k_q),
    .rd_word_o  (rd_word)
  );

  assign bus.msg_ready   = (state_q == S_FILL) && rdy_en_q;
  assign bus.data_out    = (state_q == S_STREAM) ? rd_word : hold_q;
  assign bus.flag_0_15   = (state_q != S_STREAM);
  assign bus.block_full  = (state_q == S_HASH);
  assign bus.first_block = first_q;
  assign bus.last_block  = final_q;
  assign bus.msg_done    = done_q;
  assign bus.busy        = !((state_q == S_FILL) && (idx_q == '0) && first_q);

endmodule
